data_out_sel_ctrl: RTL and testbench
====================================

# data_out_sel_ctrl

Controller that schedules the output-mode select of the Power / RL / IQUV output multiplexer. It accepts mode-change requests from the host register bank and applies them only at spectrum-frame boundaries, so a downstream packetizer never receives a torn frame. It also inserts a flush gap after each switch and re-synchronises to the new stream before re-enabling output. It sits between the register bank and the mux select input, and monitors the mux's registered outputs.

## Interface
- BITWIDTH, 7, sets counter widths; Power frame = 2^(BITWIDTH+2) words, RL = 2^(BITWIDTH+3), IQUV = 2^(BITWIDTH+4)
- GAP_CYCLES, 4, cycles `out_enable` is held low after `sel` changes (≥2, covers mux latency)
- TIMEOUT, 65535, cycles without a valid word in WAIT_EOF before a forced switch
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous and active-low
- mode_req  in  2  requested mode: 0 Power, 1 RL, 2 IQUV, 3 RL counter test
- mode_req_valid  in  1  single-cycle strobe qualifying `mode_req`
- en_sync_in  in  1  mux `en_sync_out`, i.e. the word-valid flag
- cnt_sync_in  in  BITWIDTH+4  mux `cnt_sync_out`, the word index within the frame
- sel  out  2  mux select, registered
- out_enable  out  1  downstream may consume words while high
- busy  out  1  a request is pending or a switch is in progress
- mode_ack  out  1  one-cycle pulse when the requested mode becomes active
- timeout_err  out  1  sticky; set by a forced switch, cleared only by reset
- frame_cnt  out  16  completed frames since the last switch, wraps

## Operation
- last(m): index of the last word in a frame of mode m. It equals 2^(BITWIDTH+2)-1 for mode 0, 2^(BITWIDTH+3)-1 for modes 1 and 3, and 2^(BITWIDTH+4)-1 for mode 2. Compare against zero-extended values.
- eof: `en_sync_in` && `cnt_sync_in` == last(sel).
- Pending register: a `mode_req_valid` strobe in any state stores `mode_req` and sets the pending flag. If a strobe arrives while a request is already pending, the newer request replaces the older one.
- States:
  - SYNC: `out_enable`=0. Go to RUN on eof. The RUN entry edge sets `out_enable`=1 and clears `frame_cnt`.
  - RUN: `out_enable`=1. On eof, `frame_cnt` += 1.
    - If pending and the pending mode equals `sel`: clear pending, pulse `mode_ack`, no switch.
    - If pending and the pending mode differs from `sel`: go to WAIT_EOF.
  - WAIT_EOF: `out_enable` stays 1 until eof, and `frame_cnt` increments on that eof. On eof: `sel` ← pending mode, clear pending, `out_enable` ← 0, go to GAP. A new strobe here only updates the target mode.
  - WAIT_EOF timeout: a counter resets on every cycle with `en_sync_in`=1. When it reaches TIMEOUT, take the same switch transition and set `timeout_err`.
  - GAP: count GAP_CYCLES, then go to SYNC.
  - Switch completion: the SYNC→RUN edge that follows a switch pulses `mode_ack`.
  - A strobe arriving in GAP or SYNC stays pending and is acted on once RUN is entered.
- `busy` = pending flag, or state ∈ {WAIT_EOF, GAP, SYNC}.
- Reset values: state SYNC, `sel`=0, `out_enable`=0, `busy`=1 (state SYNC), `mode_ack`=0, `timeout_err`=0, `frame_cnt`=0, pending=0, timer=0.
- Reset asserted mid-switch: all state is discarded. `sel` returns to 0 and the pending request is lost.

## Timing
- All outputs are registered and change only on the rising edge of `clk`.
- `sel` changes on the edge that samples the eof word.
- Because the mux is registered, the first word in the new format appears 2 cycles later. GAP_CYCLES ≥ 2 guarantees those words are masked.
- After the switch edge, `out_enable` re-asserts no earlier than GAP_CYCLES + 1 cycles later, on the edge sampling the first eof of the new mode. The first consumed word is therefore index 0 of the following frame.
- `mode_ack` is high for exactly one cycle, on the same edge that raises `out_enable`.
- For a same-mode request, `mode_ack` rises 1 cycle after the strobe (RUN only).

## Structure
- Shared package: mode encodings (MODE_POWER=0, MODE_RL=1, MODE_IQUV=2, MODE_TEST=3), a state enum, and the function last(mode, BITWIDTH).
- The block is one FSM module. The GAP and timeout counters are a natural sub-module `sat_timer` (load, count-down, done flag); instantiate it twice.

## Test plan
- Reset behaviour: hold `rst_n`=0, then stream Power frames with BITWIDTH=7 → `sel`=0, and `out_enable` rises on the edge sampling cnt=511.
- Power→IQUV switch: in RUN, strobe `mode_req`=2 at cnt=100 → `sel` stays 0 until cnt=511, then becomes 2. Hold `out_enable`=0 until cnt=2047 of IQUV. `mode_ack` pulses once and `frame_cnt` restarts at 0.
- Request overwrite: strobe 1 and then 2 within the same frame → only mode 2 is applied and one `mode_ack` is issued.
- Same-mode request: strobe `mode_req`=0 while in Power RUN → `mode_ack` next cycle, `sel` unchanged, `out_enable` stays 1.
- Stalled source: drop `en_sync_in` in WAIT_EOF with TIMEOUT=16 → forced switch after 16 cycles and `timeout_err`=1.
- Reset mid-switch: assert `rst_n`=0 during GAP → `sel`=0, `busy`=1, no `mode_ack`.

Source files
------------

// File: rtl/data_out_sel_ctrl_pkg.sv
// ============================================================================
// data_out_sel_ctrl_pkg : mode encodings, FSM states, frame-length helper
// Revision 1.0
// ============================================================================
`default_nettype none

package data_out_sel_ctrl_pkg;

  localparam logic [1:0] MODE_POWER = 2'd0;
  localparam logic [1:0] MODE_RL    = 2'd1;
  localparam logic [1:0] MODE_IQUV  = 2'd2;
  localparam logic [1:0] MODE_TEST  = 2'd3;

  typedef enum logic [1:0] {
    ST_SYNC     = 2'd0,
    ST_RUN      = 2'd1,
    ST_WAIT_EOF = 2'd2,
    ST_GAP      = 2'd3
  } state_e;

  // Index of the final word of a frame in the given mode, zero-extended to 32 bits.
  function automatic logic [31:0] last_word(input logic [1:0] mode, input int unsigned bw);
    logic [31:0] one;
    one = 32'd1;
    case (mode)
      MODE_POWER: return (one << (bw + 32'd2)) - 32'd1;
      MODE_IQUV:  return (one << (bw + 32'd4)) - 32'd1;
      default:    return (one << (bw + 32'd3)) - 32'd1;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_out_sel_ctrl_if.sv
// ============================================================================
// data_out_sel_ctrl_if : host request, mux feedback and control outputs
// Revision 1.0
// ============================================================================
`default_nettype none

interface data_out_sel_ctrl_if #(
  parameter int BITWIDTH = 7
);
  logic [1:0]          mode_req;
  logic                mode_req_valid;
  logic                en_sync_in;
  logic [BITWIDTH+3:0] cnt_sync_in;
  logic [1:0]          sel;
  logic                out_enable;
  logic                busy;
  logic                mode_ack;
  logic                timeout_err;
  logic [15:0]         frame_cnt;

  modport master (
    output mode_req, mode_req_valid, en_sync_in, cnt_sync_in,
    input  sel, out_enable, busy, mode_ack, timeout_err, frame_cnt
  );

  modport slave (
    input  mode_req, mode_req_valid, en_sync_in, cnt_sync_in,
    output sel, out_enable, busy, mode_ack, timeout_err, frame_cnt
  );
endinterface

`default_nettype wire

// File: rtl/data_out_sel_ctrl_sat_timer.sv
// ============================================================================
// data_out_sel_ctrl_sat_timer : loadable down-counter saturating at zero
// Revision 1.0
// ============================================================================
`default_nettype none

module data_out_sel_ctrl_sat_timer #(
  parameter int WIDTH = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load_i,
  input  wire logic [WIDTH-1:0] load_val_i,
  input  wire logic             dec_i,
  output logic                  done_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/data_out_sel_ctrl.sv
// ============================================================================
// data_out_sel_ctrl : frame-aligned output-mode switching for the Power/RL/IQUV mux
// Revision 1.0
// ============================================================================
`default_nettype none

module data_out_sel_ctrl
  import data_out_sel_ctrl_pkg::*;
#(
  parameter int BITWIDTH   = 7,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 65535
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  data_out_sel_ctrl_if.slave bus
);

  // Timers are loaded with N-1 so that done coincides with the N-th counted edge.
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  pmode_q, pmode_d;
  logic        pend_q, pend_d;
  logic        oe_q, oe_d;
  logic        ack_q, ack_d;
  logic        terr_q, terr_d;
  logic        busy_q, busy_d;
  logic        swd_q, swd_d;
  logic [15:0] frame_q, frame_d;

  logic w_eof, w_switch, w_idle, w_tmo_done, w_gap_done;

  assign w_eof  = bus.en_sync_in && (32'(bus.cnt_sync_in) == last_word(sel_q, BITWIDTH));
  assign w_idle = (state_q == ST_WAIT_EOF) && !bus.en_sync_in;

  data_out_sel_ctrl_sat_timer #(.WIDTH(TW)) u_tmo_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (!w_idle),
    .load_val_i(TMO_LOAD),
    .dec_i     (w_idle),
    .done_o    (w_tmo_done)
  );

  data_out_sel_ctrl_sat_timer #(.WIDTH(GW)) u_gap_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (w_switch),
    .load_val_i(GAP_LOAD),
    .dec_i     (state_q == ST_GAP),
    .done_o    (w_gap_done)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    pmode_d  = pmode_q;
    pend_d   = pend_q;
    oe_d     = oe_q;
    ack_d    = 1'b0;
    terr_d   = terr_q;
    swd_d    = swd_q;
    frame_d  = frame_q;
    w_switch = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (w_eof) begin
          state_d = ST_RUN;
          oe_d    = 1'b1;
          frame_d = '0;
          ack_d   = swd_q;
          swd_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (w_eof) frame_d = frame_q + 16'd1;
        if (pend_q) begin
          if (pmode_q == sel_q) begin
            pend_d = 1'b0;
            ack_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_EOF;
          end
        end
      end
      ST_WAIT_EOF: begin
        if (w_eof) begin
          frame_d  = frame_q + 16'd1;
          w_switch = 1'b1;
        end else if (w_idle && w_tmo_done) begin
          terr_d   = 1'b1;
          w_switch = 1'b1;
        end
      end
      ST_GAP: begin
        if (w_gap_done) state_d = ST_SYNC;
      end
      default: state_d = ST_SYNC;
    endcase

    if (w_switch) begin
      sel_d   = pmode_q;
      pend_d  = 1'b0;
      oe_d    = 1'b0;
      swd_d   = 1'b1;
      state_d = ST_GAP;
    end

    // A strobe always wins over a same-edge clear so no request is dropped.
    if (bus.mode_req_valid) begin
      pend_d  = 1'b1;
      pmode_d = bus.mode_req;
    end

    busy_d = pend_d || (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_SYNC;
      sel_q   <= MODE_POWER;
      pmode_q <= MODE_POWER;
      pend_q  <= 1'b0;
      oe_q    <= 1'b0;
      ack_q   <= 1'b0;
      terr_q  <= 1'b0;
      busy_q  <= 1'b1;
      swd_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      pmode_q <= pmode_d;
      pend_q  <= pend_d;
      oe_q    <= oe_d;
      ack_q   <= ack_d;
      terr_q  <= terr_d;
      busy_q  <= busy_d;
      swd_q   <= swd_d;
      frame_q <= frame_d;
    end
  end

  assign bus.sel         = sel_q;
  assign bus.out_enable  = oe_q;
  assign bus.busy        = busy_q;
  assign bus.mode_ack    = ack_q;
  assign bus.timeout_err = terr_q;
  assign bus.frame_cnt   = frame_q;

endmodule

`default_nettype wire

// File: tb/tb_data_out_sel_ctrl.sv
// ============================================================================
// tb_data_out_sel_ctrl : randomized mux/host stimulus with scoreboard checking
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_data_out_sel_ctrl;

  localparam int BW  = 7;
  localparam int GAP = 4;
  localparam int TMO = 16;
  localparam int CW  = BW + 4;

  localparam int P_SYNC = 0;
  localparam int P_RUN  = 1;
  localparam int P_WAIT = 2;
  localparam int P_GAP  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_out_sel_ctrl_if #(.BITWIDTH(BW)) bus ();

  data_out_sel_ctrl #(
    .BITWIDTH  (BW),
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TMO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic        oe;
    logic        busy;
    logic        ack;
    logic        terr;
    logic [15:0] fc;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int ph = P_SYNC, msel = 0, pmode = 0, mframes = 0, idle = 0, gapn = 0;
  bit mpend = 0, moe = 0, mack = 0, mterr = 0, mswitched = 0;

  // Mux emulation state
  bit stall = 0;
  int s1 = 0, s2 = 0, cur_fmt = 0, idx = 0;

  function automatic int frame_words(input int m);
    int ext;
    ext = (m == 0) ? 2 : (m == 2) ? 4 : 3;
    return 1 << (BW + ext);
  endfunction

  task automatic model_step(input bit r, input bit rv, input int rm, input bit en, input int cnt);
    bit eof, do_sw;
    if (!r) begin
      ph = P_SYNC; msel = 0; pmode = 0; mpend = 0; moe = 0; mack = 0;
      mterr = 0; mframes = 0; idle = 0; gapn = 0; mswitched = 0;
      return;
    end
    eof   = en && (cnt == frame_words(msel) - 1);
    do_sw = 0;
    mack  = 0;
    case (ph)
      P_SYNC: if (eof) begin
        ph = P_RUN; moe = 1; mframes = 0;
        if (mswitched) begin mack = 1; mswitched = 0; end
      end
      P_RUN: begin
        if (eof) mframes = (mframes + 1) % 65536;
        if (mpend) begin
          if (pmode == msel) begin mpend = 0; mack = 1; end
          else begin ph = P_WAIT; idle = 0; end
        end
      end
      P_WAIT: begin
        idle = en ? 0 : idle + 1;
        if (eof) begin mframes = (mframes + 1) % 65536; do_sw = 1; end
        else if (idle >= TMO) begin mterr = 1; do_sw = 1; end
      end
      default: begin
        gapn++;
        if (gapn == GAP) ph = P_SYNC;
      end
    endcase
    if (do_sw) begin
      msel = pmode; mpend = 0; moe = 0; ph = P_GAP; gapn = 0; mswitched = 1;
    end
    if (rv) begin mpend = 1; pmode = rm; end
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.sel  = 2'(msel);
    o.oe   = moe;
    o.busy = mpend || (ph != P_RUN);
    o.ack  = mack;
    o.terr = mterr;
    o.fc   = 16'(mframes);
    return o;
  endfunction

  // Registered mux: a new select shows up in the word stream two edges later.
  task automatic drive_word();
    s2 = s1;
    s1 = msel;
    if (s2 != cur_fmt) begin cur_fmt = s2; idx = 0; end
    if (!stall && ($urandom_range(0, 7) != 0)) begin
      bus.en_sync_in  = 1'b1;
      bus.cnt_sync_in = CW'(idx);
      idx = (idx == frame_words(cur_fmt) - 1) ? 0 : idx + 1;
    end else begin
      bus.en_sync_in = 1'b0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(rst_n, bus.mode_req_valid, int'(bus.mode_req), bus.en_sync_in, int'(bus.cnt_sync_in));
    exp_q.push_back(model_obs());
    #1;
    bus.mode_req_valid = 1'b0;
    drive_word();
  endtask

  task automatic strobe(input int m);
    bus.mode_req       = 2'(m);
    bus.mode_req_valid = 1'b1;
    cycle();
  endtask

  task automatic run_until(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (ph != target && n < budget) begin
      cycle();
      n++;
    end
    if (ph != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_%s: phase %0d after %0d cycles, required phase %0d", tag, ph, n, target);
    end
  endtask

  task automatic wait_word(input int w, input int budget);
    int n;
    n = 0;
    while (!(ph == P_RUN && bus.en_sync_in && int'(bus.cnt_sync_in) == w) && n < budget) begin
      cycle();
      n++;
    end
    if (n >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_word: index %0d not seen in RUN within %0d cycles, required it", w, budget);
    end
  endtask

  // Monitor: one expected record per clock edge, compared mid-cycle.
  initial begin
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {bus.sel, bus.out_enable, bus.busy, bus.mode_ack, bus.timeout_err, bus.frame_cnt};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got sel=%0d oe=%b busy=%b ack=%b terr=%b fc=%0d, expected sel=%0d oe=%b busy=%b ack=%b terr=%b fc=%0d",
                   $time, a.sel, a.oe, a.busy, a.ack, a.terr, a.fc,
                   e.sel, e.oe, e.busy, e.ack, e.terr, e.fc);
        end
      end
    end
  end

  initial begin
    bus.mode_req       = 2'd0;
    bus.mode_req_valid = 1'b0;
    bus.en_sync_in     = 1'b0;
    bus.cnt_sync_in    = '0;

    repeat (4) cycle();
    rst_n = 1'b1;
    run_until(P_RUN, 3000, "first_run");

    repeat (20) cycle();
    strobe(0);
    repeat (30) cycle();

    wait_word(100, 3000);
    strobe(2);
    run_until(P_GAP, 3000, "to_iquv");
    run_until(P_RUN, 8000, "iquv_run");

    repeat (10) cycle();
    strobe(1);
    repeat (5) cycle();
    strobe(0);
    run_until(P_GAP, 8000, "overwrite");
    run_until(P_RUN, 3000, "power_run");

    repeat (10) cycle();
    strobe(3);
    run_until(P_WAIT, 50, "test_wait");
    stall = 1'b1;
    run_until(P_GAP, 100, "timeout");
    stall = 1'b0;
    run_until(P_RUN, 5000, "test_run");

    repeat (10) cycle();
    strobe(1);
    run_until(P_GAP, 5000, "rl_gap");
    cycle();
    rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    run_until(P_RUN, 3000, "after_reset");

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(1, 1200)) cycle();
      strobe(int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) strobe(int'($urandom_range(0, 3)));
    end
    repeat (3000) cycle();

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
